// File: rtl/cache_set.sv
// ============================================================================
//  Module      : cache_set
//  Description : One line of a direct-mapped cache. Holds a 5-bit tag, valid
//                and dirty bits and four 16-bit data words. Tag compare and
//                word read are combinational; fills and compare-writes update
//                state on the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_set (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [0:1]  word,
  input  logic        comp,
  input  logic        write,
  input  logic [0:4]  tag_in,
  input  logic [0:15] data_in,
  input  logic        valid_in,
  output logic        hit,
  output logic        dirty,
  output logic [0:4]  tag_out,
  output logic [0:15] data_out,
  output logic        valid
);

  localparam int C_NUM_WORDS = 4;

  logic [0:4]  r_tag;
  logic        r_valid;
  logic        r_dirty;
  logic [0:15] r_data [0:C_NUM_WORDS-1];

  logic        w_match;
  logic        w_fill;
  logic        w_cwrite;
  logic        w_word_we;

  // A stored line only matches when it is valid; an invalid line never hits.
  assign w_match   = r_valid && (tag_in == r_tag);
  // Access-write always lands; compare-write lands only on a match.
  assign w_fill    = enable && !comp && write;
  assign w_cwrite  = enable &&  comp && write && w_match;
  assign w_word_we = w_fill || w_cwrite;

  // Tag, valid and dirty: fill reloads tag/valid and cleans the line,
  // a landed compare-write marks it dirty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
    end else if (w_fill) begin
      r_tag   <= tag_in;
      r_valid <= valid_in;
      r_dirty <= 1'b0;
    end else if (w_cwrite) begin
      r_dirty <= 1'b1;
    end
  end

  // One register per data word; only the addressed word is written.
  generate
    for (genvar gi = 0; gi < C_NUM_WORDS; gi++) begin : g_word
      // Word gi captures data_in when it is the target of a landed write.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data[gi] <= '0;
        end else if (w_word_we && (word == gi[1:0])) begin
          r_data[gi] <= data_in;
        end
      end
    end
  endgenerate

  // Outputs reflect pre-edge state and are forced to zero when deselected.
  always_comb begin
    hit      = 1'b0;
    dirty    = 1'b0;
    valid    = 1'b0;
    tag_out  = '0;
    data_out = '0;
    if (enable) begin
      hit      = comp && w_match;
      dirty    = r_dirty;
      valid    = r_valid;
      tag_out  = r_tag;
      data_out = r_data[word];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_set.sv
// ============================================================================
//  Module      : tb_cache_set
//  Description : Directed self-checking bench for cache_set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_set;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [0:1]  word;
  logic        comp;
  logic        write;
  logic [0:4]  tag_in;
  logic [0:15] data_in;
  logic        valid_in;
  logic        hit;
  logic        dirty;
  logic [0:4]  tag_out;
  logic [0:15] data_out;
  logic        valid;

  int n_tests;
  int n_fail;

  cache_set u_dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .word     (word),
    .comp     (comp),
    .write    (write),
    .tag_in   (tag_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .hit      (hit),
    .dirty    (dirty),
    .tag_out  (tag_out),
    .data_out (data_out),
    .valid    (valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic cmp, input logic wr,
                       input logic [1:0] w, input logic [4:0] t,
                       input logic [15:0] d, input logic vin);
    enable   = en;
    comp     = cmp;
    write    = wr;
    word     = w;
    tag_in   = t;
    data_in  = d;
    valid_in = vin;
  endtask

  task automatic check_all(input string tag, input logic h, input logic dt,
                           input logic v, input logic [4:0] t, input logic [15:0] d);
    check({tag, ".hit"},   32'(hit),      32'(h));
    check({tag, ".dirty"}, 32'(dirty),    32'(dt));
    check({tag, ".valid"}, 32'(valid),    32'(v));
    check({tag, ".tag"},   32'(tag_out),  32'(t));
    check({tag, ".data"},  32'(data_out), 32'(d));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'h00, 16'h0000, 1'b0);

    // Reset asserted mid-cycle, before any clock edge.
    #3 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'h00, 16'h0000, 1'b0);
    #1 check_all("reset", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    // A fill presented while reset is held must not land.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 5'h13, 16'hBEEF, 1'b1);
    @(posedge clk); #1;
    check_all("reset_blocks_write", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'h00, 16'h0000, 1'b0);
    @(negedge clk);

    // Fill word 2, then compare-read it.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 5'h13, 16'hBEEF, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 5'h13, 16'h0000, 1'b0);
    #1 check_all("fill_hit", 1'b1, 1'b0, 1'b1, 5'h13, 16'hBEEF);

    // Tag miss.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 5'h12, 16'h0000, 1'b0);
    #1 check_all("tag_miss", 1'b0, 1'b0, 1'b1, 5'h13, 16'hBEEF);

    // Access-read with matching tag never reports a hit.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 5'h13, 16'h0000, 1'b0);
    #1 check("access_read.hit", 32'(hit), 32'h0);

    // Compare-write hit: hit and outputs show pre-write state.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 5'h13, 16'h1234, 1'b0);
    #1 check_all("cwrite_pre", 1'b1, 1'b0, 1'b1, 5'h13, 16'h0000);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 5'h13, 16'h0000, 1'b0);
    #1 check_all("cwrite_w1", 1'b1, 1'b1, 1'b1, 5'h13, 16'h1234);
    word = 2'd2;
    #1 check("cwrite_w2.data", 32'(data_out), 32'hBEEF);

    // Compare-write miss leaves state alone.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 5'h00, 16'hFFFF, 1'b0);
    #1 check("cwrite_miss.hit", 32'(hit), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 5'h00, 16'h0000, 1'b0);
    #1 check_all("cwrite_miss_after", 1'b0, 1'b1, 1'b1, 5'h13, 16'h1234);

    // Disabled: outputs zero and a write across an edge is blocked.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 5'h07, 16'hAAAA, 1'b0);
    #1 check_all("disabled", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 5'h00, 16'h0000, 1'b0);
    #1 check_all("disabled_after", 1'b0, 1'b1, 1'b1, 5'h13, 16'h1234);

    // Fill with valid_in=0: line never hits, dirty cleared, other words kept.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 5'h07, 16'h5555, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'h07, 16'h0000, 1'b0);
    #1 check_all("invalid_fill", 1'b0, 1'b0, 1'b0, 5'h07, 16'h5555);
    word = 2'd1;
    #1 check("invalid_fill_w1.data", 32'(data_out), 32'h1234);
    // Compare-write to an invalid line with matching tag must not land.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 5'h07, 16'h9999, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'h07, 16'h0000, 1'b0);
    #1 check("invalid_cwrite.data", 32'(data_out), 32'h5555);
    check("invalid_cwrite.dirty", 32'(dirty), 32'h0);

    // Build a dirty line, then reset during a compare-write.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'd3, 5'h0A, 16'h0F0F, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd3, 5'h0A, 16'h1111, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd3, 5'h0A, 16'h2222, 1'b0);
    #1 check_all("dirty_line", 1'b1, 1'b1, 1'b1, 5'h0A, 16'h1111);
    rst = 1'b0;
    #1 check_all("async_reset", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 5'h0A, 16'h0000, 1'b0);
    #1 check_all("after_reset", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);

    // First edge after reset release accepts a fill.
    #1 drive(1'b1, 1'b0, 1'b1, 2'd3, 5'h1F, 16'hCAFE, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 5'h1F, 16'h0000, 1'b0);
    #1 check_all("first_write", 1'b1, 1'b0, 1'b1, 5'h1F, 16'hCAFE);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
